// File: rtl/riscv_fetch_pkg.sv
// Shared constants and entry layout for the fetch front end.
package riscv_fetch_pkg;

  localparam int PC_STEP     = 4;
  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/pipelined_fetch_unit_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
interface pipelined_fetch_unit_if
  import riscv_fetch_pkg::*;
#(
  parameter int PC_W  = FETCH_PC_W,
  parameter int INS_W = FETCH_INS_W
);
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;
  logic             inst_valid;
  logic             inst_ready;
  logic [INS_W-1:0] inst;
  logic [PC_W-1:0]  inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs; flush wins over push.
module fetch_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pipelined_fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited requests to a 1-cycle
// instruction memory and queues returned instructions toward decode.
module pipelined_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_pc,
  pipelined_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int E_W   = PC_W + INS_W;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  req_pc;
  logic             inflight;
  logic             kill;
  logic             started;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  logic [E_W-1:0]   head;
  logic             unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  // An issued request reserves a queue slot until its response lands.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = started & fetch_en & ~redirect_valid
                   & (occupancy < (CNT_W+1)'(FQ_DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;

  assign push           = bus.imem_rvalid & inflight & ~kill & ~redirect_valid;
  assign bus.inst_valid = (count != '0) & ~redirect_valid;
  assign pop            = bus.inst_valid & bus.inst_ready;
  assign {bus.inst_pc, bus.inst} = head;

  // started keeps imem_req low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        pc       <= {redirect_pc[PC_W-1:2], 2'b00};
        inflight <= 1'b0;
        kill     <= inflight;
      end else begin
        kill     <= 1'b0;
        inflight <= issue;
        if (issue) begin
          pc     <= pc + PC_W'(PC_STEP);
          req_pc <= pc;
        end
      end
    end
  end

  fetch_fifo #(
    .W     (E_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({req_pc, bus.imem_rdata}),
    .dout  (head),
    .count (count)
  );
endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Randomised and directed bench for pipelined_fetch_unit against a queue-based model.
module tb_pipelined_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_en = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [8:0] redirect_pc = '0;

  pipelined_fetch_unit_if #(.PC_W(9), .INS_W(32)) bus ();

  pipelined_fetch_unit #(
    .PC_W(9), .INS_W(32), .FQ_DEPTH(DEPTH), .RESET_PC(9'h000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_req = -1;
  int first_valid = -1;

  fetch_entry_t q[$];
  logic [8:0]   m_pc;
  logic [8:0]   m_out_addr;
  bit           m_out, m_kill, m_started;
  int           req_log[$];
  int           pop_log[$];
  bit           s_req;
  logic [8:0]   s_addr;

  function automatic logic [31:0] mem_data(logic [8:0] a);
    return {7'h55, a, 7'h2A, ~a};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 9'h000;
    m_out = 0;
    m_kill = 0;
    m_started = 0;
    m_out_addr = '0;
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance the model.
  task automatic step_check();
    bit exp_req, exp_valid, do_push;
    fetch_entry_t e;
    if (reset) begin
      model_reset();
      chk("rst_imem_req", 64'(bus.imem_req), 64'(0));
      chk("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
      chk("rst_inst", 64'(bus.inst), 64'(0));
      chk("rst_inst_pc", 64'(bus.inst_pc), 64'(0));
      s_req = 0;
      return;
    end
    exp_valid = (q.size() != 0) && !redirect_valid;
    exp_req   = m_started && fetch_en && !redirect_valid && ((q.size() + int'(m_out)) < DEPTH);
    chk("imem_req", 64'(bus.imem_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    chk("inst_valid", 64'(bus.inst_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("inst", 64'(bus.inst), 64'(q[0].inst));
      chk("inst_pc", 64'(bus.inst_pc), 64'(q[0].pc));
    end
    if (exp_req && first_req < 0) first_req = cyc;
    if (exp_valid && first_valid < 0) first_valid = cyc;
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;

    do_push = bus.imem_rvalid && m_out && !m_kill && !redirect_valid;
    e.pc    = m_out_addr;
    e.inst  = mem_data(m_out_addr);
    if (redirect_valid) begin
      q.delete();
      m_kill = m_out;
      m_out  = 0;
      m_pc   = redirect_pc & 9'h1FC;
    end else begin
      if (exp_valid && bus.inst_ready) begin
        pop_log.push_back(int'(q[0].pc));
        void'(q.pop_front());
      end
      if (do_push) q.push_back(e);
      m_kill = 0;
      if (exp_req) begin
        req_log.push_back(int'(m_pc));
        m_out_addr = m_pc;
        m_out = 1;
        m_pc = m_pc + 9'd4;
      end else begin
        m_out = 0;
      end
    end
    m_started = 1;
  endtask

  // Memory answers one cycle after a request; occasional spurious rvalid must be ignored.
  task automatic finish_cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_rvalid = s_req | ($urandom_range(0, 19) == 0);
    bus.imem_rdata  = mem_data(s_addr);
  endtask

  task automatic cycle(input bit fe, input bit rv, input logic [8:0] rpc, input bit rdy);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bus.inst_ready = rdy;
    @(negedge clk);
    step_check();
    finish_cycle();
  endtask

  initial begin
    bus.imem_rvalid = 0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 0;
    s_req = 0;
    s_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) cycle(1, 0, 9'h0, 1);

    // Streaming from reset
    reset = 0;
    clear_logs();
    first_req = -1;
    first_valid = -1;
    repeat (10) cycle(1, 0, 9'h0, 1);
    for (int i = 0; i < 6; i++) chk("stream_addr", 64'(req_log[i]), 64'(4 * i));
    for (int i = 0; i < 4; i++) chk("stream_pc", 64'(pop_log[i]), 64'(4 * i));
    chk("first_latency", 64'(first_valid - first_req), 64'(2));

    // Decode stall: exactly DEPTH requests, then in-order drain
    cycle(1, 1, 9'h000, 0);
    clear_logs();
    repeat (10) cycle(1, 0, 9'h0, 0);
    chk("stall_req_count", 64'(req_log.size()), 64'(4));
    clear_logs();
    repeat (8) cycle(1, 0, 9'h0, 1);
    for (int i = 0; i < 5; i++) chk("drain_pc", 64'(pop_log[i]), 64'(4 * i));
    chk("resume_addr", 64'(req_log[0]), 64'(16));

    // Redirect right after the request to 0x0C
    cycle(1, 1, 9'h000, 1);
    repeat (4) cycle(1, 0, 9'h0, 1);
    cycle(1, 1, 9'h040, 1);
    clear_logs();
    repeat (6) cycle(1, 0, 9'h0, 1);
    chk("redir_addr", 64'(req_log[0]), 64'(9'h040));
    chk("redir_pc", 64'(pop_log[0]), 64'(9'h040));

    // Unaligned redirect and PC wrap
    cycle(1, 1, 9'h043, 1);
    clear_logs();
    repeat (3) cycle(1, 0, 9'h0, 1);
    chk("align_addr", 64'(req_log[0]), 64'(9'h040));
    cycle(1, 1, 9'h1F8, 1);
    clear_logs();
    repeat (6) cycle(1, 0, 9'h0, 1);
    chk("wrap_addr0", 64'(req_log[0]), 64'(9'h1F8));
    chk("wrap_addr1", 64'(req_log[1]), 64'(9'h1FC));
    chk("wrap_addr2", 64'(req_log[2]), 64'(9'h000));
    chk("wrap_pc2", 64'(pop_log[2]), 64'(9'h000));

    // Asynchronous reset with two queued entries and one request in flight
    cycle(1, 1, 9'h080, 0);
    repeat (3) cycle(1, 0, 9'h0, 0);
    fetch_en = 1;
    redirect_valid = 0;
    bus.inst_ready = 0;
    #1;
    chk("pre_rst_valid", 64'(bus.inst_valid), 64'(1));
    reset = 1;
    #1;
    chk("async_req", 64'(bus.imem_req), 64'(0));
    chk("async_valid", 64'(bus.inst_valid), 64'(0));
    #1;
    reset = 0;
    model_reset();
    clear_logs();
    @(negedge clk);
    step_check();
    finish_cycle();
    repeat (6) cycle(1, 0, 9'h0, 1);
    chk("post_rst_addr", 64'(req_log[0]), 64'(9'h000));
    chk("post_rst_pc", 64'(pop_log[0]), 64'(9'h000));

    // fetch_en low: no requests, queue drains, pc held
    cycle(1, 1, 9'h100, 1);
    repeat (3) cycle(1, 0, 9'h0, 1);
    clear_logs();
    repeat (5) cycle(0, 0, 9'h0, 1);
    chk("disabled_reqs", 64'(req_log.size()), 64'(0));
    chk("disabled_empty", 64'(bus.inst_valid), 64'(0));
    cycle(1, 0, 9'h0, 1);
    chk("reenable_addr", 64'(req_log[0]), 64'(9'h10C));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
            9'($urandom), $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_fetch_unit.md
Name: pipelined_fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the free-running PC register + adder + direct instruction-memory read of the single-cycle datapath.
- Owns the PC and issues requests to a 1-cycle-latency instruction memory.
- Buffers returned instructions, with their PCs, in a small FIFO behind a valid/ready handshake to decode.
- Supports branch/jump redirect with flush and a fetch-enable stall.

Parameters:
- PC_W, 9, PC and instruction-memory byte-address width.
- INS_W, 32, instruction width.
- FQ_DEPTH, 4, fetch-queue entries; power of two, >=2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  when low, no new requests issue; in-flight response still accepted.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  PC_W  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  request strobe to instruction memory.
- imem_addr  out  PC_W  request byte address.
- imem_rvalid  in  1  response valid, exactly 1 cycle after an accepted imem_req.
- imem_rdata  in  INS_W  response instruction.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst  out  INS_W  head instruction.
- inst_pc  out  PC_W  PC of head instruction.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, queue empty, inflight=0, kill=0. Outputs: imem_req=0, inst_valid=0, inst=0, inst_pc=0. This holds while reset is asserted and at the first edge after release.
- Credit rule: imem_req = fetch_en & !redirect_valid & (count + inflight < FQ_DEPTH). imem_addr = pc.
- On each issued request:
  - pc <= pc + 4, modulo 2^PC_W; wraps from 2^PC_W-4 to 0 silently.
  - inflight <= 1 for the next cycle.
  - At most 1 outstanding request exists at a time; back-to-back issue is allowed because the response returns the following cycle.
- Response handling: imem_rvalid with inflight=1 and kill=0 pushes {pc_of_request, imem_rdata}. imem_rvalid with inflight=0 is ignored.
- Latency: request in cycle N gives imem_rvalid in N+1 and inst_valid at head in N+2 (no bypass). Sustained throughput is 1 instruction/cycle while decode is ready and fetch_en is high.
- Handshake:
  - Pop when inst_valid & inst_ready.
  - inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
  - inst_valid is combinationally forced 0 in a redirect_valid cycle, so no pop occurs that cycle.
- Full/empty:
  - The credit rule guarantees a push never targets a full queue.
  - Push and pop in the same cycle are allowed at any occupancy, including count=FQ_DEPTH-1 with a push arriving.
  - Empty: inst_valid=0; inst/inst_pc hold their last value (don't-care).
- Redirect, cycle R:
  - Queue cleared; pc <= {redirect_pc[PC_W-1:2],2'b00}; no request in R.
  - kill <= inflight, so a response arriving in R+1 from a pre-R request is discarded.
  - A response arriving in R itself is also discarded.
  - First request to the new PC issues in R+1 (if fetch_en); its instruction is visible at R+3.
- Back-to-back redirects: each one restarts; the last one wins.
- fetch_en low: pc holds; the queue drains normally.
- Reset mid-operation: all state cleared immediately; an in-flight response after reset release is ignored (inflight=0).

Decomposition:
- Package riscv_fetch_pkg:
  - PC_STEP=4 constant.
  - Packed struct fetch_entry_t {pc, inst}, parametrised via package localparams matching the defaults.
- Sub-module fetch_fifo:
  - Synchronous FIFO: width = PC_W+INS_W, depth FQ_DEPTH.
  - push, pop, flush (flush has priority over push), count output, async active-high reset.
- Top level holds pc, inflight, kill and the credit logic.

Test Plan:
- Reset release, fetch_en=1, inst_ready=1, memory returns addr-tagged data: imem_addr sequence 0,4,8,...; first inst_valid 2 cycles after the first imem_req; inst_pc 0,4,8,... with no gaps.
- inst_ready=0 for 10 cycles: imem_req stops after exactly FQ_DEPTH(4) requests. Releasing inst_ready drains 0,4,8,12 in order, then fetch resumes at 16.
- Redirect to 0x40 in the cycle after a request to 0x0C: the 0x0C response is dropped, queue flushed, next imem_addr=0x40. First inst_pc seen after redirect = 0x40.
- redirect_pc=0x43: fetch resumes at 0x40. Start PC 0x1F8 (PC_W=9): addresses 0x1F8, 0x1FC, 0x000.
- Queue holds 2 entries plus an inflight request; assert reset asynchronously mid-cycle: inst_valid and imem_req drop immediately. After release, the first imem_addr = RESET_PC and the stale response is not enqueued.
- fetch_en=0 for 5 cycles with inst_ready=1: no imem_req; the queue empties to inst_valid=0; pc unchanged on re-enable.
